// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main control FSM for a multicycle MIPS-style datapath.
//
// Steps each instruction through fetch, decode and an opcode-specific
// sequence of execute / memory / write-back states, producing the datapath
// enables and mux selects for every cycle.
//
// Ports:
//   clk            single clock, all state updates on the rising edge
//   rst            synchronous active-high reset (forces FETCH)
//   op             6-bit opcode field from the instruction register
//   mem_ready      memory completes the current access this cycle
//   reg_dst        write-address mux select (0 = rt, 1 = rd)
//   reg_write, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
//   iord, mem_to_reg, alu_src_a   single-bit datapath enables/selects
//   alu_src_b      ALU B select (00 reg B, 01 const 4, 10 imm, 11 imm<<2)
//   alu_op         00 add, 01 sub, 10 decode by funct
//   pc_source      00 ALU result, 01 ALUOut, 10 jump target
//   state          current state code, for debug
//   instr_done     one-cycle pulse in the final cycle of each instruction
//
// Parameter MEM_HANDSHAKE: 1 = memory states wait for mem_ready,
//                          0 = mem_ready ignored and treated as 1.

module multicycle_ctrl #(
    parameter int unsigned MEM_HANDSHAKE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       instr_done
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    state_t cur_state;
    state_t next_state;
    logic   ready;
    logic   op_known;

    assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    assign op_known = (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
                      (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);

    always_ff @(posedge clk) begin
        if (rst)
            cur_state <= FETCH;
        else
            cur_state <= next_state;
    end

    // Only DECODE and MEMADR look at op; every other state ignores it.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            FETCH:  if (ready) next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXEC;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI:      next_state = ADDIEX;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR: next_state = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (ready) next_state = MEMWB;
            MEMWB:  next_state = FETCH;
            MEMWR:  if (ready) next_state = FETCH;
            EXEC:   next_state = ALUWB;
            ALUWB:  next_state = FETCH;
            BRANCH: next_state = FETCH;
            JUMP:   next_state = FETCH;
            ADDIEX: next_state = ADDIWB;
            ADDIWB: next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // Moore outputs, all forced low while rst is high (even though the
    // register already reads FETCH then, ir_write/pc_write must stay 0).
    // In FETCH the PC/IR updates wait for ready so a stalled fetch
    // does not advance the PC more than once.
    always_comb begin
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        state         = 4'd0;
        if (!rst) begin
            state = cur_state;
            case (cur_state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = ready;
                    pc_write  = ready;
                end
                DECODE: begin
                    alu_src_b  = 2'b11;
                    instr_done = !op_known;
                end
                MEMADR, ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWR: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = ready;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                ALUWB: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                ADDIWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
